// File: rtl/dmem_responder_if.sv
// Load/store handshake between the core (master) and the data-memory responder (slave).
// Signal names keep the responder's view: *_i are driven by the core, *_o by the responder.
interface dmem_responder_if;
   logic        valid_i;
   logic        wen_i;
   logic        byte_not_word_i;
   logic [31:0] write_data_i;
   logic [31:0] addr_i;
   logic        yumi_i;
   logic        yumi_o;
   logic        valid_o;
   logic [31:0] read_data_o;
   logic        busy_o;

   modport master (
      output valid_i, wen_i, byte_not_word_i, write_data_i, addr_i, yumi_i,
      input  yumi_o, valid_o, read_data_o, busy_o
   );

   modport slave (
      input  valid_i, wen_i, byte_not_word_i, write_data_i, addr_i, yumi_i,
      output yumi_o, valid_o, read_data_o, busy_o
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word/byte load or store at a time, performs it on a
// byte-lane block RAM after latency_p wait cycles and holds the response until acknowledged.
module dmem_responder #(
   parameter int unsigned addr_width_p = 10,
   parameter int unsigned latency_p    = 2
) (
   input  logic             clk,
   input  logic             reset,
   dmem_responder_if.slave  bus
);
   localparam int unsigned depth_lp      = 1 << addr_width_p;
   localparam logic [3:0]  last_count_lp = (latency_p > 0) ? 4'(latency_p - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e                  state_reg, state_next;
   logic                    accept;
   logic                    enter_resp;
   logic [3:0]              count_reg;
   logic                    wen_reg;
   logic                    byte_reg;
   logic [31:0]             wdata_reg;
   logic [addr_width_p+1:0] addr_reg;

   logic                    eff_wen;
   logic                    eff_byte;
   logic [31:0]             eff_wdata;
   logic [addr_width_p+1:0] eff_addr;
   logic [addr_width_p-1:0] eff_index;
   logic [1:0]              eff_lane;
   logic [3:0]              lane_we;
   logic [31:0]             rd_word;
   logic [31:0]             resp_data;
   logic                    unused_addr_bits;

   assign unused_addr_bits = ^bus.addr_i[31:addr_width_p+2];

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: if (accept) state_next = (latency_p == 0) ? RESP : BUSY;
         BUSY: if (count_reg == last_count_lp) state_next = RESP;
         RESP: if (bus.yumi_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      accept          = (state_reg == IDLE) & bus.valid_i & ~reset;
      enter_resp      = ~reset & (state_reg != RESP) & (state_next == RESP);
      bus.yumi_o      = accept;
      bus.busy_o      = (state_reg != IDLE);
      bus.valid_o     = (state_reg == RESP);
      bus.read_data_o = (state_reg == RESP) ? resp_data : 32'd0;
   end

   // ---------------- Request latch and wait counter ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= 4'd0;
         wen_reg   <= 1'b0;
         byte_reg  <= 1'b0;
         wdata_reg <= 32'd0;
         addr_reg  <= '0;
      end else if (accept) begin
         count_reg <= 4'd0;
         wen_reg   <= bus.wen_i;
         byte_reg  <= bus.byte_not_word_i;
         wdata_reg <= bus.write_data_i;
         addr_reg  <= bus.addr_i[addr_width_p+1:0];
      end else if (state_reg == BUSY) begin
         count_reg <= count_reg + 4'd1;
      end
   end

   // With latency 0 the access happens on the accept edge, before the latch is loaded.
   assign eff_wen   = accept ? bus.wen_i                      : wen_reg;
   assign eff_byte  = accept ? bus.byte_not_word_i            : byte_reg;
   assign eff_wdata = accept ? bus.write_data_i               : wdata_reg;
   assign eff_addr  = accept ? bus.addr_i[addr_width_p+1:0]   : addr_reg;
   assign eff_index = eff_addr[addr_width_p+1:2];
   assign eff_lane  = eff_addr[1:0];

   // ---------------- Byte-lane RAMs ----------------
   // One RAM per lane gives byte stores without a read-modify-write.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [depth_lp];
      logic [7:0] rd_q;

      assign lane_we[gi] = enter_resp & eff_wen & (~eff_byte | (eff_lane == 2'(gi)));

      always_ff @(posedge clk) begin
         if (lane_we[gi]) begin
            mem[eff_index] <= eff_byte ? eff_wdata[7:0] : eff_wdata[8*gi +: 8];
         end
         if (enter_resp) begin
            rd_q <= mem[eff_index];
         end
      end

      assign rd_word[8*gi +: 8] = rd_q;
   end

   // ---------------- Response formatting ----------------
   always_comb begin
      resp_data = 32'd0;
      if (!wen_reg) begin
         if (!byte_reg) begin
            resp_data = rd_word;
         end else begin
            unique case (addr_reg[1:0])
               2'd0:    resp_data = {24'd0, rd_word[7:0]};
               2'd1:    resp_data = {24'd0, rd_word[15:8]};
               2'd2:    resp_data = {24'd0, rd_word[23:16]};
               default: resp_data = {24'd0, rd_word[31:24]};
            endcase
         end
      end
   end
endmodule
